// File: rtl/lif_neuron_seq.sv
// lif_neuron_seq: time-multiplexed LIF engine scanning 18 neurons per timestep.
// Define ADAPT_TH_EN for per-neuron adaptive thresholds.
module lif_neuron_seq #(
   parameter int unsigned N_NEURON   = 18,
   parameter logic [15:0] V_TH       = 16'h4000,
   parameter int unsigned LEAK_SHIFT = 4,
   parameter logic [15:0] INHBT_W    = 16'h0200,
   parameter int unsigned REFRAC_CYC = 2,
   parameter logic [15:0] THETA_INC  = 16'h0100
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_start,
   input  logic                    i_s_init,
   input  logic [N_NEURON*16-1:0]  i_cur,
   input  logic [4:0]              i_inhbt,
   output logic                    o_valid,
   output logic                    o_spike,
   output logic [4:0]              o_neuron_idx,
   output logic                    o_s_init,
   output logic                    o_cnt_clr,
   output logic                    o_busy,
   output logic                    o_done
);
   typedef enum logic [2:0] {IDLE, LOAD, CLR, SCAN, ISCAN, FIN} state_t;
   localparam logic [4:0] LAST = 5'(N_NEURON - 1);
   state_t state_q, state_d;
   logic [4:0] cnt_q, cnt_d;
   logic [N_NEURON*16-1:0] cur_q;
   logic [4:0] inh_q;
   logic spike_q, spike_d;
   logic [15:0] v_q [N_NEURON];
   logic [2:0] r_q [N_NEURON];
   logic [N_NEURON-1:0] ls_q;
`ifdef ADAPT_TH_EN
   logic [15:0] th_q [N_NEURON];
   logic [15:0] th_d;
`endif
   logic [4:0] p, inh_n, k;
   logic upd, frozen, fire;
   logic [15:0] cur_n, v, vl, vn, th, v_d;
   logic [16:0] s;
   logic [20:0] inh, diff;
   logic [2:0] r_d;
   // Neuron p is computed one cycle ahead of its appearance on the output stream.
   always_comb begin
      upd    = (state_q == LOAD) || (state_q == SCAN && cnt_q != LAST);
      p      = (state_q == SCAN && cnt_q != LAST) ? cnt_q + 5'd1 : 5'd0;
      cur_n  = (state_q == LOAD) ? i_cur[{p, 4'b0} +: 16] : cur_q[{p, 4'b0} +: 16];
      inh_n  = (state_q == LOAD) ? i_inhbt : inh_q;
      v      = v_q[p];
      vl     = v - (v >> LEAK_SHIFT);
      s      = {1'b0, vl} + {1'b0, cur_n};
      k      = (inh_n > {4'b0, ls_q[p]}) ? inh_n - {4'b0, ls_q[p]} : 5'd0;
      inh    = 21'(k) * 21'(INHBT_W);
      diff   = {4'b0, s} - inh;
      vn     = ({4'b0, s} <= inh) ? 16'd0 : (diff > 21'h00FFFF ? 16'hFFFF : diff[15:0]);
`ifdef ADAPT_TH_EN
      th     = th_q[p];
      th_d   = (th > 16'hFFFF - THETA_INC) ? 16'hFFFF : th + THETA_INC;
`else
      th     = V_TH;
`endif
      frozen = r_q[p] != 3'd0;
      fire   = !frozen && vn >= th;
      v_d    = frozen ? v : fire ? 16'd0 : vn;
      r_d    = frozen ? r_q[p] - 3'd1 : fire ? 3'(REFRAC_CYC) : 3'd0;
      spike_d = upd && fire;
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE:        state_d = i_s_init ? CLR : i_start ? LOAD : IDLE;
         LOAD:        begin state_d = SCAN; cnt_d = 5'd0; end
         CLR:         begin state_d = ISCAN; cnt_d = 5'd0; end
         SCAN, ISCAN: begin
            state_d = (cnt_q == LAST) ? FIN : state_q;
            cnt_d   = (cnt_q == LAST) ? cnt_q : cnt_q + 5'd1;
         end
         FIN:         state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         cur_q   <= '0;
         inh_q   <= 5'd0;
         spike_q <= 1'b0;
         ls_q    <= '0;
         for (int i = 0; i < N_NEURON; i++) begin
            v_q[i] <= 16'd0;
            r_q[i] <= 3'd0;
`ifdef ADAPT_TH_EN
            th_q[i] <= V_TH;
`endif
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         spike_q <= spike_d;
         if (state_q == LOAD) begin
            cur_q <= i_cur;
            inh_q <= i_inhbt;
         end
         if (state_q == CLR) begin
            ls_q <= '0;
            for (int i = 0; i < N_NEURON; i++) begin
               v_q[i] <= 16'd0;
               r_q[i] <= 3'd0;
`ifdef ADAPT_TH_EN
               th_q[i] <= V_TH;
`endif
            end
         end else if (upd) begin
            v_q[p]  <= v_d;
            r_q[p]  <= r_d;
            ls_q[p] <= fire;
`ifdef ADAPT_TH_EN
            if (fire) th_q[p] <= th_d;
`endif
         end
      end
   end
   assign o_valid      = state_q == SCAN || state_q == ISCAN;
   assign o_s_init     = state_q == ISCAN;
   assign o_spike      = spike_q;
   assign o_neuron_idx = cnt_q;
   assign o_cnt_clr    = state_q == CLR;
   assign o_busy       = state_q != IDLE;
   assign o_done       = state_q == FIN;
endmodule

// File: tb/tb_lif_neuron_seq.sv
// tb_lif_neuron_seq: directed table plus randomized timesteps against a behavioural LIF model.
module tb_lif_neuron_seq;
   localparam int VTH = 'h4000;
   logic clk = 0, rst_n = 0, i_start = 0, i_s_init = 0;
   logic [287:0] i_cur = '0;
   logic [4:0] i_inhbt = '0;
   logic o_valid, o_spike, o_s_init, o_cnt_clr, o_busy, o_done;
   logic [4:0] o_neuron_idx;
   int n_chk = 0, n_fail = 0;
   int mv[18], mr[18], mls[18], mth[18];

   always #5 clk = ~clk;

   lif_neuron_seq dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_s_init(i_s_init),
      .i_cur(i_cur), .i_inhbt(i_inhbt), .o_valid(o_valid), .o_spike(o_spike),
      .o_neuron_idx(o_neuron_idx), .o_s_init(o_s_init), .o_cnt_clr(o_cnt_clr),
      .o_busy(o_busy), .o_done(o_done)
   );

   typedef struct {
      bit init; bit start; bit poke; logic [4:0] inh; int n; logic [15:0] c; logic [17:0] exp;
   } vec_t;
   vec_t tbl[13];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One timestep of the spec's LIF rules, in plain integer arithmetic.
   function automatic logic [17:0] model(bit init, int inh, logic [287:0] cur);
      logic [17:0] m = '0;
      for (int n = 0; n < 18; n++) begin
         int vl, s, k, d, vn;
         if (init) begin
            mv[n] = 0; mr[n] = 0; mls[n] = 0; mth[n] = VTH;
            continue;
         end
         if (mr[n] > 0) begin
            mr[n]--; mls[n] = 0;
            continue;
         end
         vl = mv[n] - mv[n] / 16;
         s  = vl + int'(cur[n*16 +: 16]);
         k  = inh - mls[n];
         if (k < 0) k = 0;
         d  = s - k * 'h200;
         vn = d <= 0 ? 0 : (d > 'hFFFF ? 'hFFFF : d);
`ifdef ADAPT_TH_EN
         if (vn >= mth[n]) begin
            m[n] = 1; mv[n] = 0; mr[n] = 2; mls[n] = 1;
            mth[n] = mth[n] + 'h100 > 'hFFFF ? 'hFFFF : mth[n] + 'h100;
         end
`else
         if (vn >= VTH) begin
            m[n] = 1; mv[n] = 0; mr[n] = 2; mls[n] = 1;
         end
`endif
         else begin
            mv[n] = vn; mls[n] = 0;
         end
      end
      return m;
   endfunction

   task automatic step(bit init, bit start, bit poke, logic [4:0] inh, logic [287:0] cur,
                       logic [17:0] exp, bit use_exp);
      logic [17:0] e, m;
      @(negedge clk);
      i_cur = cur; i_inhbt = inh; i_s_init = init; i_start = start;
      m = model(init, int'(inh), cur);
      e = use_exp ? exp : m;
      @(negedge clk);
      i_start = 0; i_s_init = 0;
      chk("busy_t1", o_busy, 1);
      chk("cnt_clr", o_cnt_clr, init);
      chk("valid_t1", o_valid, 0);
      for (int j = 0; j < 18; j++) begin
         @(negedge clk);
         chk("valid", o_valid, 1);
         chk("idx", o_neuron_idx, j);
         chk("s_init", o_s_init, init);
         chk("spike", o_spike, e[j]);
         chk("cnt_clr_scan", o_cnt_clr, 0);
         if (poke && j == 3) begin
            i_start = 1;
            i_cur = {9{$urandom()}};
         end
         if (poke && j == 4) i_start = 0;
      end
      @(negedge clk);
      chk("done", o_done, 1);
      chk("valid_fin", o_valid, 0);
      chk("busy_fin", o_busy, 1);
      @(negedge clk);
      chk("busy_idle", o_busy, 0);
      chk("done_idle", o_done, 0);
   endtask

   initial begin
      logic [287:0] cur;
      tbl[0]  = '{0, 1, 0, 5'd0, 0, 16'h0000, 18'h0};
      tbl[1]  = '{0, 1, 0, 5'd0, 3, 16'h4000, 18'h8};
      tbl[2]  = '{0, 1, 0, 5'd0, 3, 16'h4000, 18'h0};
      tbl[3]  = '{0, 1, 0, 5'd0, 3, 16'h4000, 18'h0};
`ifdef ADAPT_TH_EN
      tbl[4]  = '{0, 1, 0, 5'd0, 3, 16'h4000, 18'h0};
`else
      tbl[4]  = '{0, 1, 0, 5'd0, 3, 16'h4000, 18'h8};
`endif
      tbl[5]  = '{1, 0, 0, 5'd0, 0, 16'h0000, 18'h0};
      tbl[6]  = '{0, 1, 0, 5'd0, 0, 16'h2000, 18'h0};
      tbl[7]  = '{0, 1, 0, 5'd0, 0, 16'h0000, 18'h0};
      tbl[8]  = '{0, 1, 0, 5'd0, 0, 16'h2200, 18'h0};
      tbl[9]  = '{1, 1, 1, 5'd0, 0, 16'h0000, 18'h0};
      tbl[10] = '{0, 1, 0, 5'd2, 5, 16'h0300, 18'h0};
      tbl[11] = '{0, 1, 0, 5'd2, 5, 16'h4400, 18'h20};
      tbl[12] = '{0, 1, 0, 5'd0, 0, 16'h0000, 18'h0};
      void'(model(1, 0, '0));
      repeat (3) @(negedge clk);
      chk("rst_valid", o_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_idx", o_neuron_idx, 0);
      rst_n = 1;
      @(negedge clk);
      chk("idle_busy", o_busy, 0);
      chk("idle_spike", o_spike, 0);
      chk("idle_done", o_done, 0);
      foreach (tbl[i]) begin
         cur = '0;
         cur[tbl[i].n*16 +: 16] = tbl[i].c;
         step(tbl[i].init, tbl[i].start, tbl[i].poke, tbl[i].inh, cur, tbl[i].exp, 1);
      end
      for (int t = 0; t < 24; t++) begin
         bit init = $urandom_range(0, 7) == 0;
         for (int n = 0; n < 18; n++) cur[n*16 +: 16] = 16'($urandom_range(0, 'h2800));
         step(init, !init, t % 5 == 2, 5'($urandom_range(0, 6)), cur, '0, 0);
      end
      @(negedge clk);
      i_start = 1;
      @(negedge clk);
      i_start = 0;
      repeat (5) @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("abort_valid", o_valid, 0);
      chk("abort_busy", o_busy, 0);
      chk("abort_idx", o_neuron_idx, 0);
      @(negedge clk);
      rst_n = 1;
      void'(model(1, 0, '0));
      cur = '0;
      cur[7*16 +: 16] = 16'h4000;
      step(0, 1, 0, 5'd0, cur, 18'h80, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
